lm_sm_sequencer: RTL and testbench
==================================

Name: lm_sm_sequencer

Overview:
- Decode-stage controller that expands an LM/SM multiple-register instruction into one micro-op per set bit of its 8-bit register mask.
- Drives the stage-2 pipeline register's register-override and first-op controls:
  - modify_ir: rewrites IR[11:9] with the selected register.
  - modify_pr2_ra: the selected register index.
  - first_multiple: marks the first micro-op of a sequence.
- Stalls fetch/stage 1 until the last micro-op issues.
- Supplies a per-transfer word offset to the memory address adder.

Parameters:
- OPC_LM, 4'b0110, opcode (IR[15:12]) of load-multiple.
- OPC_SM, 4'b0111, opcode (IR[15:12]) of store-multiple.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk edge.
- ir_in  in  16  instruction currently leaving stage 1.
- valid_in  in  1  ir_in holds a real instruction.
- stall_in  in  1  downstream hazard stall; hold all state.
- flush  in  1  branch/jump flush of stage 1/2 contents.
- modify_ir  out  1  stage-2 register must overwrite IR[11:9].
- modify_pr2_ra  out  3  register index for the current micro-op.
- first_multiple  out  1  current micro-op is the first of its sequence.
- stall_fetch  out  1  hold PC and stage-1 register this cycle.
- addr_offset  out  4  number of transfers already issued in this sequence (0..7).
- busy  out  1  state is BUSY.
- mask_empty  out  1  LM/SM with zero mask; write-back and memory write must be suppressed.

Behaviour:
- is_mult = valid_in & (ir_in[15:12]==OPC_LM | ir_in[15:12]==OPC_SM).
- States: IDLE, BUSY. Registers: state, rem_q[7:0], cnt_q[3:0].
- cur_mask selection: ir_in[7:0] in IDLE; rem_q in BUSY.
- Bit i of the mask selects register Ri. Issue order is lowest index first.
- Combinational outputs, valid in the same cycle as the inputs:
  - IDLE & is_mult & cur_mask!=0:
    - modify_ir=1.
    - modify_pr2_ra=index of lowest set bit.
    - first_multiple=1, addr_offset=0.
    - stall_fetch=1 iff popcount(cur_mask)>1.
  - IDLE & is_mult & cur_mask==0:
    - mask_empty=1, first_multiple=1, modify_ir=0, stall_fetch=0.
    - Single pass-through; no state change.
  - BUSY:
    - modify_ir=1, first_multiple=0.
    - modify_pr2_ra=lowest set bit of rem_q.
    - addr_offset=cnt_q.
    - stall_fetch=1 unless rem_q has exactly one bit set (last micro-op).
  - All other cases: all outputs 0.
- Advance (rising edge, reset=1, flush=0, stall_in=0):
  - IDLE & is_mult & popcount>1: rem_q<=cur_mask with lowest set bit cleared; cnt_q<=1; state<=BUSY.
  - BUSY & not last: rem_q<=rem_q with lowest set bit cleared; cnt_q<=cnt_q+1.
  - BUSY & last: state<=IDLE; rem_q<=0; cnt_q<=0.
- stall_in=1 (flush=0): state, rem_q, cnt_q hold. Outputs stay stable, recomputed from held state.
- flush=1: overrides stall_in and advance.
  - Next state IDLE, rem_q=0, cnt_q=0.
  - Same-cycle modify_ir, first_multiple, stall_fetch, mask_empty forced 0.
  - The stage-2 register inserts its NOP.
- ir_in is ignored while BUSY. The held stage-1 instruction re-presents the same LM/SM and must not restart it.
- Latency: an N-bit mask issues in exactly N non-stalled cycles. stall_fetch is high for N-1 of them. An N=1 mask issues in 1 cycle with no stall.
- cnt_q never exceeds 7; wrap is not possible.
- Reset (reset=0 at edge): state=IDLE, rem_q=0, cnt_q=0. While reset=0, all outputs are driven 0 regardless of inputs. Reset mid-sequence abandons it.

Test Plan:
1. Reset held low 2 cycles with ir_in=LM mask 8'hFF, valid_in=1 -> all outputs 0; after release, first cycle shows ra=0, first_multiple=1, stall_fetch=1.
2. LM mask 8'b1010_0100 -> ra sequence 2,5,7 on consecutive cycles. addr_offset 0,1,2. stall_fetch 1,1,0. first_multiple 1,0,0. busy 0,1,1. Then IDLE.
3. SM mask 8'b0000_1000 -> single cycle: ra=3, modify_ir=1, first_multiple=1, stall_fetch=0, busy stays 0.
4. LM mask 8'h00 -> mask_empty=1, first_multiple=1, modify_ir=0, stall_fetch=0 for one cycle.
5. LM mask 8'h0F with stall_in=1 for 2 cycles during ra=1 -> ra=1 and addr_offset=1 held for 3 cycles, then ra=2, ra=3; total issue completes 2 cycles late.
6. LM mask 8'hFF, flush=1 at third micro-op -> same cycle: modify_ir=0, stall_fetch=0; next cycle busy=0, addr_offset=0; a following ADD passes with all outputs 0.

Source files
------------

// File: rtl/lm_sm_sequencer_if.sv
// Decode-stage handshake between stage 1 and the LM/SM micro-op sequencer.
// master drives the instruction and pipeline controls; slave is the sequencer.
interface lm_sm_sequencer_if;
    logic [15:0] ir_in;
    logic        valid_in;
    logic        stall_in;
    logic        flush;
    logic        modify_ir;
    logic [2:0]  modify_pr2_ra;
    logic        first_multiple;
    logic        stall_fetch;
    logic [3:0]  addr_offset;
    logic        busy;
    logic        mask_empty;

    modport master (
        output ir_in, valid_in, stall_in, flush,
        input  modify_ir, modify_pr2_ra, first_multiple, stall_fetch, addr_offset, busy,
               mask_empty
    );

    modport slave (
        input  ir_in, valid_in, stall_in, flush,
        output modify_ir, modify_pr2_ra, first_multiple, stall_fetch, addr_offset, busy,
               mask_empty
    );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Expands an LM/SM instruction into one micro-op per set mask bit, lowest register first,
// stalling fetch until the last micro-op issues.
module lm_sm_sequencer #(
    parameter logic [3:0] OPC_LM = 4'b0110,
    parameter logic [3:0] OPC_SM = 4'b0111
) (
    input logic              clk,
    input logic              reset,
    lm_sm_sequencer_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e     state_q, state_d;
    logic [7:0] rem_q, rem_d;
    logic [3:0] cnt_q, cnt_d;

    logic       is_mult;
    logic [7:0] cur_mask;
    logic [7:0] cleared;
    logic       multi;
    logic [2:0] low_idx;

    assign is_mult  = bus.valid_in &
                      ((bus.ir_in[15:12] == OPC_LM) || (bus.ir_in[15:12] == OPC_SM));
    assign cur_mask = (state_q == StBusy) ? rem_q : bus.ir_in[7:0];
    assign cleared  = cur_mask & (cur_mask - 8'd1);
    // More than one bit set means this is not the last micro-op.
    assign multi    = (cleared != 8'd0);

    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cur_mask[i]) low_idx = 3'(i);
        end
    end

    always_comb begin
        state_d            = state_q;
        rem_d              = rem_q;
        cnt_d              = cnt_q;
        bus.modify_ir      = 1'b0;
        bus.modify_pr2_ra  = 3'd0;
        bus.first_multiple = 1'b0;
        bus.stall_fetch    = 1'b0;
        bus.addr_offset    = 4'd0;
        bus.mask_empty     = 1'b0;
        bus.busy           = reset && (state_q == StBusy);

        unique case (state_q)
            StIdle: begin
                if (is_mult) begin
                    bus.first_multiple = 1'b1;
                    if (cur_mask != 8'd0) begin
                        bus.modify_ir     = 1'b1;
                        bus.modify_pr2_ra = low_idx;
                        bus.stall_fetch   = multi;
                        if (multi) begin
                            state_d = StBusy;
                            rem_d   = cleared;
                            cnt_d   = 4'd1;
                        end
                    end else begin
                        bus.mask_empty = 1'b1;
                    end
                end
            end
            StBusy: begin
                bus.modify_ir     = 1'b1;
                bus.modify_pr2_ra = low_idx;
                bus.addr_offset   = cnt_q;
                bus.stall_fetch   = multi;
                if (multi) begin
                    rem_d = cleared;
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    state_d = StIdle;
                    rem_d   = 8'd0;
                    cnt_d   = 4'd0;
                end
            end
            default: ;
        endcase

        if (bus.stall_in) begin
            state_d = state_q;
            rem_d   = rem_q;
            cnt_d   = cnt_q;
        end

        // Flush discards the sequence; stage 2 substitutes its own NOP.
        if (bus.flush) begin
            state_d            = StIdle;
            rem_d              = 8'd0;
            cnt_d              = 4'd0;
            bus.modify_ir      = 1'b0;
            bus.first_multiple = 1'b0;
            bus.stall_fetch    = 1'b0;
            bus.mask_empty     = 1'b0;
        end

        if (!reset) begin
            bus.modify_ir      = 1'b0;
            bus.modify_pr2_ra  = 3'd0;
            bus.first_multiple = 1'b0;
            bus.stall_fetch    = 1'b0;
            bus.addr_offset    = 4'd0;
            bus.mask_empty     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            rem_q   <= 8'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed vector table for the LM/SM sequencer followed by random stimulus checked
// against a queue-based model of the pending register list.
module tb_lm_sm_sequencer;

    typedef struct packed {
        logic [2:0] ra;
        logic       mi;
        logic       fm;
        logic       sf;
        logic [3:0] off;
        logic       busy;
        logic       me;
    } outs_t;

    typedef struct {
        logic        rst;
        logic [15:0] ir;
        logic        v;
        logic        st;
        logic        fl;
        outs_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    int   pend[$];
    int   issued = 0;

    always #5 clk = ~clk;

    lm_sm_sequencer_if bus ();

    lm_sm_sequencer dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic vec_t mk(logic rst, logic [15:0] ir, logic v, logic st, logic fl,
                                logic [2:0] ra, logic mi, logic fm, logic sf,
                                logic [3:0] off, logic busy, logic me);
        vec_t r;
        r.rst = rst; r.ir = ir; r.v = v; r.st = st; r.fl = fl;
        r.e = '{ra: ra, mi: mi, fm: fm, sf: sf, off: off, busy: busy, me: me};
        return r;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.ra   = bus.modify_pr2_ra;
        o.mi   = bus.modify_ir;
        o.fm   = bus.first_multiple;
        o.sf   = bus.stall_fetch;
        o.off  = bus.addr_offset;
        o.busy = bus.busy;
        o.me   = bus.mask_empty;
        return o;
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all(string tag, outs_t act, outs_t exp, bit skip_idx);
        if (!skip_idx) begin
            chk({tag, ".modify_pr2_ra"}, {1'b0, act.ra}, {1'b0, exp.ra});
            chk({tag, ".addr_offset"}, act.off, exp.off);
        end
        chk({tag, ".modify_ir"}, {3'b0, act.mi}, {3'b0, exp.mi});
        chk({tag, ".first_multiple"}, {3'b0, act.fm}, {3'b0, exp.fm});
        chk({tag, ".stall_fetch"}, {3'b0, act.sf}, {3'b0, exp.sf});
        chk({tag, ".busy"}, {3'b0, act.busy}, {3'b0, exp.busy});
        chk({tag, ".mask_empty"}, {3'b0, act.me}, {3'b0, exp.me});
    endtask

    function automatic bit is_mult(logic [15:0] ir, logic v);
        return v && (ir[15:12] == 4'b0110 || ir[15:12] == 4'b0111);
    endfunction

    // Expected outputs from the list of registers still to transfer.
    function automatic outs_t model_out(logic rst, logic [15:0] ir, logic v, logic fl);
        outs_t o;
        int    bits[$];
        o = '0;
        if (!rst) return o;
        if (pend.size() > 0) begin
            o.busy = 1'b1;
            o.mi   = 1'b1;
            o.ra   = 3'(pend[0]);
            o.off  = 4'(issued);
            o.sf   = (pend.size() > 1);
        end else if (is_mult(ir, v)) begin
            for (int i = 0; i < 8; i++) if (ir[i]) bits.push_back(i);
            o.fm = 1'b1;
            if (bits.size() == 0) begin
                o.me = 1'b1;
            end else begin
                o.mi = 1'b1;
                o.ra = 3'(bits[0]);
                o.sf = (bits.size() > 1);
            end
        end
        if (fl) begin
            o.mi = 1'b0; o.fm = 1'b0; o.sf = 1'b0; o.me = 1'b0;
        end
        return o;
    endfunction

    task automatic model_edge(logic rst, logic [15:0] ir, logic v, logic st, logic fl);
        int bits[$];
        if (!rst || fl) begin
            pend.delete();
            issued = 0;
        end else if (!st) begin
            if (pend.size() > 0) begin
                void'(pend.pop_front());
                issued++;
                if (pend.size() == 0) issued = 0;
            end else if (is_mult(ir, v)) begin
                for (int i = 0; i < 8; i++) if (ir[i]) bits.push_back(i);
                if (bits.size() > 1) begin
                    pend = bits;
                    void'(pend.pop_front());
                    issued = 1;
                end
            end
        end
    endtask

    task automatic drive(logic rst, logic [15:0] ir, logic v, logic st, logic fl);
        reset        = rst;
        bus.ir_in    = ir;
        bus.valid_in = v;
        bus.stall_in = st;
        bus.flush    = fl;
    endtask

    initial begin
        vec_t        tbl[$];
        outs_t       exp;
        logic        rst, v, st, fl;
        logic [15:0] ir;
        logic [7:0]  mask;
        logic [3:0]  opc;

        // Reset with LM 0xFF presented, then the full 8-op sequence with ir_in ignored.
        tbl.push_back(mk(0, 16'h60FF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h60FF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 16'h60FF, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        for (int k = 1; k < 8; k++)
            tbl.push_back(mk(1, 16'h60FF, 1, 0, 0, 3'(k), 1, 0, (k != 7), 4'(k), 1, 0));
        tbl.push_back(mk(1, 16'h60A4, 1, 0, 0, 2, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 16'h60A4, 1, 0, 0, 5, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 16'h60A4, 1, 0, 0, 7, 1, 0, 0, 2, 1, 0));
        tbl.push_back(mk(1, 16'h7008, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 16'h6000, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 16'h1234, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 16'h60FF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Stall held on the second micro-op of LM 0x0F.
        tbl.push_back(mk(1, 16'h600F, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 16'h600F, 1, 1, 0, 1, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 16'h600F, 1, 1, 0, 1, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 16'h600F, 1, 0, 0, 1, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 16'h600F, 1, 0, 0, 2, 1, 0, 1, 2, 1, 0));
        tbl.push_back(mk(1, 16'h600F, 1, 0, 0, 3, 1, 0, 0, 3, 1, 0));
        // Flush on the third micro-op, then an ADD.
        tbl.push_back(mk(1, 16'h60FF, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 16'h60FF, 1, 0, 0, 1, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 16'h60FF, 1, 0, 1, 2, 0, 0, 0, 2, 1, 0));
        tbl.push_back(mk(1, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Flush while idle must not start a sequence.
        tbl.push_back(mk(1, 16'h70FF, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Reset mid-sequence abandons it.
        tbl.push_back(mk(1, 16'h60FF, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 16'h60FF, 1, 0, 0, 1, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 16'h60FF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].ir, tbl[i].v, tbl[i].st, tbl[i].fl);
            @(negedge clk);
            cmp_all($sformatf("vec%0d", i), sample(), tbl[i].e, 1'b0);
            @(posedge clk);
            #1;
            model_edge(tbl[i].rst, tbl[i].ir, tbl[i].v, tbl[i].st, tbl[i].fl);
        end

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 63) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            st  = ($urandom_range(0, 4) == 0);
            v   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: opc = 4'b0110;
                1: opc = 4'b0111;
                default: opc = 4'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: mask = 8'h00;
                1: mask = 8'h01 << $urandom_range(0, 7);
                2: mask = 8'hFF;
                default: mask = 8'($urandom);
            endcase
            ir = {opc, 4'($urandom), mask};
            drive(rst, ir, v, st, fl);
            exp = model_out(rst, ir, v, fl);
            @(negedge clk);
            cmp_all($sformatf("rnd%0d", n), sample(), exp, fl && rst);
            @(posedge clk);
            #1;
            model_edge(rst, ir, v, st, fl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
